// File: rtl/parking_ctrl_multi.sv
// Multi-slot parking controller: entry FSM (detect, password, confirm, lowest-free allocation) plus password-checked exit with lockout.
// Latency: enter2 -> assign_valid 2 cycles, enter3 -> exit_gate 1 cycle; no backpressure, every strobe is consumed in its own cycle.
module parking_ctrl_multi #(
  parameter  int NUM_SLOTS     = 16,
  parameter  int PW_WIDTH      = 128,
  parameter  int ENTRY_TIMEOUT = 1000,
  parameter  int MAX_TRIES     = 3,
  parameter  int LOCK_CYCLES   = 500,
  localparam int SLOT_W        = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ir,
  input  logic [PW_WIDTH-1:0]  pass_entry1,
  input  logic                 enter1,
  input  logic [PW_WIDTH-1:0]  pass_entry2,
  input  logic                 enter2,
  input  logic [SLOT_W-1:0]    exit_num,
  input  logic [PW_WIDTH-1:0]  pass_exit,
  input  logic                 enter3,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic [SLOT_W:0]      free_count,
  output logic                 full,
  output logic                 assign_valid,
  output logic [SLOT_W-1:0]    assigned_slot,
  output logic                 entry_gate,
  output logic                 exit_gate,
  output logic                 pswd_inc_entry,
  output logic                 pswd_inc_exit,
  output logic                 entry_timeout,
  output logic                 lockout
);

  localparam int FREE_W = SLOT_W + 1;
  localparam int TMO_W  = $clog2(ENTRY_TIMEOUT + 1);
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ENTRY_TIMEOUT - 1);
  localparam logic [TRY_W-1:0]  TRY_LAST  = TRY_W'(MAX_TRIES - 1);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_PW1, WAIT_PW2, ALLOC} state_t;

  state_t               state, state_nxt;
  logic [TMO_W-1:0]     timer, timer_nxt;
  logic                 ir_q;
  logic                 ir_rise;
  logic [PW_WIDTH-1:0]  pw_latch;
  logic [PW_WIDTH-1:0]  pw_store [NUM_SLOTS];

  logic                 latch_en, latch_clr;
  logic                 alloc_fire, mismatch_fire, timeout_fire;
  logic                 alloc_ok;
  logic [SLOT_W-1:0]    alloc_idx;

  logic                 exit_req, exit_hit, exit_ok;
  logic [PW_WIDTH-1:0]  exit_pw;
  logic [NUM_SLOTS-1:0] occ_set, occ_clr;
  logic [FREE_W-1:0]    free_nxt;

  logic [TRY_W-1:0]     try_cnt;
  logic [LOCK_W-1:0]    lock_timer;

  assign ir_rise = ir & ~ir_q;

  // Lowest-index free slot, taken from registered occupancy so a same-cycle release is never picked.
  always_comb begin
    alloc_ok  = 1'b0;
    alloc_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occupied[i]) begin
        alloc_ok  = 1'b1;
        alloc_idx = SLOT_W'(i);
      end
    end
  end

  always_comb begin
    exit_req = enter3 & ~lockout;
    exit_hit = (int'(exit_num) < NUM_SLOTS);
    exit_pw  = exit_hit ? pw_store[exit_num] : '0;
    exit_ok  = exit_req && exit_hit && occupied[exit_num] && (pass_exit == exit_pw);
  end

  always_comb begin
    occ_set  = alloc_fire ? (NUM_SLOTS'(1) << alloc_idx) : '0;
    occ_clr  = exit_ok ? (NUM_SLOTS'(1) << exit_num) : '0;
    free_nxt = free_count + FREE_W'(exit_ok) - FREE_W'(alloc_fire);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer + 1'b1;
    latch_en      = 1'b0;
    latch_clr     = 1'b0;
    alloc_fire    = 1'b0;
    mismatch_fire = 1'b0;
    timeout_fire  = 1'b0;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (ir_rise && !full) state_nxt = WAIT_PW1;
      end
      WAIT_PW1: begin
        // A strobe in the last allowed cycle still counts; timeout only when nothing arrived.
        if (enter1) begin
          latch_en  = 1'b1;
          state_nxt = WAIT_PW2;
          timer_nxt = '0;
        end else if (timer == TMO_LAST) begin
          timeout_fire = 1'b1;
          latch_clr    = 1'b1;
          state_nxt    = IDLE;
          timer_nxt    = '0;
        end
      end
      WAIT_PW2: begin
        if (enter2) begin
          timer_nxt = '0;
          if (pass_entry2 == pw_latch) begin
            state_nxt = ALLOC;
          end else begin
            mismatch_fire = 1'b1;
            state_nxt     = WAIT_PW1;
          end
        end else if (timer == TMO_LAST) begin
          timeout_fire = 1'b1;
          latch_clr    = 1'b1;
          state_nxt    = IDLE;
          timer_nxt    = '0;
        end
      end
      ALLOC: begin
        timer_nxt  = '0;
        latch_clr  = 1'b1;
        alloc_fire = alloc_ok;
        state_nxt  = IDLE;
      end
      default: begin
        timer_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q           <= 1'b0;
      pw_latch       <= '0;
      occupied       <= '0;
      free_count     <= FREE_W'(NUM_SLOTS);
      full           <= 1'b0;
      assign_valid   <= 1'b0;
      assigned_slot  <= '0;
      entry_gate     <= 1'b0;
      pswd_inc_entry <= 1'b0;
      entry_timeout  <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) pw_store[i] <= '0;
    end else begin
      ir_q           <= ir;
      assign_valid   <= alloc_fire;
      entry_gate     <= alloc_fire;
      pswd_inc_entry <= mismatch_fire;
      entry_timeout  <= timeout_fire;
      if (latch_en)       pw_latch <= pass_entry1;
      else if (latch_clr) pw_latch <= '0;
      // Allocation and release always target different slots, so both writes may land together.
      if (alloc_fire) begin
        assigned_slot       <= alloc_idx;
        pw_store[alloc_idx] <= pw_latch;
      end
      if (exit_ok) pw_store[exit_num] <= '0;
      occupied   <= (occupied & ~occ_clr) | occ_set;
      free_count <= free_nxt;
      full       <= (free_nxt == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exit_gate     <= 1'b0;
      pswd_inc_exit <= 1'b0;
      try_cnt       <= '0;
      lockout       <= 1'b0;
      lock_timer    <= '0;
    end else begin
      exit_gate     <= exit_ok;
      pswd_inc_exit <= exit_req & ~exit_ok;
      if (lockout) begin
        if (lock_timer == '0) begin
          lockout <= 1'b0;
          try_cnt <= '0;
        end else begin
          lock_timer <= lock_timer - 1'b1;
        end
      end else if (exit_ok) begin
        try_cnt <= '0;
      end else if (exit_req) begin
        try_cnt <= try_cnt + 1'b1;
        if (try_cnt == TRY_LAST) begin
          lockout    <= 1'b1;
          lock_timer <= LOCK_LOAD;
        end
      end
    end
  end

endmodule

// File: tb/tb_parking_ctrl_multi.sv
// Bench for parking_ctrl_multi: directed scenarios plus random entry/exit traffic against a per-slot array model.
module tb_parking_ctrl_multi;

  localparam int NS    = 4;
  localparam int SW    = 2;
  localparam int TMO   = 40;
  localparam int TRIES = 3;
  localparam int LOCKC = 30;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ir = 1'b0;
  logic [127:0]  pass_entry1 = '0;
  logic          enter1 = 1'b0;
  logic [127:0]  pass_entry2 = '0;
  logic          enter2 = 1'b0;
  logic [SW-1:0] exit_num = '0;
  logic [127:0]  pass_exit = '0;
  logic          enter3 = 1'b0;
  logic [NS-1:0] occupied;
  logic [SW:0]   free_count;
  logic          full, assign_valid, entry_gate, exit_gate;
  logic [SW-1:0] assigned_slot;
  logic          pswd_inc_entry, pswd_inc_exit, entry_timeout, lockout;

  parking_ctrl_multi #(
    .NUM_SLOTS(NS), .PW_WIDTH(128), .ENTRY_TIMEOUT(TMO),
    .MAX_TRIES(TRIES), .LOCK_CYCLES(LOCKC)
  ) dut (
    .clk(clk), .rst(rst), .ir(ir),
    .pass_entry1(pass_entry1), .enter1(enter1),
    .pass_entry2(pass_entry2), .enter2(enter2),
    .exit_num(exit_num), .pass_exit(pass_exit), .enter3(enter3),
    .occupied(occupied), .free_count(free_count), .full(full),
    .assign_valid(assign_valid), .assigned_slot(assigned_slot),
    .entry_gate(entry_gate), .exit_gate(exit_gate),
    .pswd_inc_entry(pswd_inc_entry), .pswd_inc_exit(pswd_inc_exit),
    .entry_timeout(entry_timeout), .lockout(lockout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit           model_occ [NS];
  logic [127:0] model_pw  [NS];
  int           model_tries;
  bit           model_locked;

  function automatic logic [NS-1:0] model_vec();
    logic [NS-1:0] v;
    for (int i = 0; i < NS; i++) v[i] = model_occ[i];
    return v;
  endfunction

  function automatic int model_free();
    int n = 0;
    for (int i = 0; i < NS; i++) if (!model_occ[i]) n++;
    return n;
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < NS; i++) if (!model_occ[i]) return i;
    return 0;
  endfunction

  function automatic logic [127:0] rand_pw();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NS; i++) begin
      model_occ[i] = 1'b0;
      model_pw[i]  = '0;
    end
    model_tries  = 0;
    model_locked = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One complete car entry; a mismatched confirm is followed by an immediate correct retry.
  task automatic do_entry(input logic [127:0] p1, input logic [127:0] p2);
    bit was_full, mism;
    int exp_slot;
    was_full = (model_free() == 0);
    mism     = !was_full && (p1 != p2);
    exp_slot = lowest_free();
    ir = 1'b1; tick(); ir = 1'b0;
    pass_entry1 = p1; enter1 = 1'b1; tick(); enter1 = 1'b0;
    pass_entry2 = p2; enter2 = 1'b1; tick(); enter2 = 1'b0;
    checks++;
    if (pswd_inc_entry !== mism) begin
      errors++; $display("FAIL entry_mismatch_pulse: got %0b expected %0b", pswd_inc_entry, mism);
    end
    if (mism) begin
      pass_entry1 = p1; enter1 = 1'b1; tick(); enter1 = 1'b0;
      pass_entry2 = p1; enter2 = 1'b1; tick(); enter2 = 1'b0;
    end
    checks++;
    if (assign_valid !== 1'b0) begin
      errors++; $display("FAIL assign_early: got %0b expected 0", assign_valid);
    end
    tick();
    checks++;
    if (assign_valid !== !was_full) begin
      errors++; $display("FAIL assign_valid: got %0b expected %0b", assign_valid, !was_full);
    end
    checks++;
    if (entry_gate !== !was_full) begin
      errors++; $display("FAIL entry_gate: got %0b expected %0b", entry_gate, !was_full);
    end
    if (!was_full) begin
      model_occ[exp_slot] = 1'b1;
      model_pw[exp_slot]  = p1;
      checks++;
      if (assigned_slot !== 2'(exp_slot)) begin
        errors++; $display("FAIL assigned_slot: got %0d expected %0d", assigned_slot, exp_slot);
      end
    end
    checks++;
    if (occupied !== model_vec()) begin
      errors++; $display("FAIL entry_occupied: got %b expected %b", occupied, model_vec());
    end
    checks++;
    if (free_count !== 3'(model_free()) || full !== (model_free() == 0)) begin
      errors++; $display("FAIL entry_free: got %0d/%0b expected %0d/%0b", free_count, full, model_free(), model_free() == 0);
    end
    tick();
    checks++;
    if (assign_valid !== 1'b0) begin
      errors++; $display("FAIL assign_pulse_width: got %0b expected 0", assign_valid);
    end
  endtask

  task automatic do_exit(input int slot, input logic [127:0] pw);
    bit locked, accept;
    locked = model_locked;
    accept = !locked && model_occ[slot] && (model_pw[slot] == pw);
    exit_num = 2'(slot); pass_exit = pw; enter3 = 1'b1; tick(); enter3 = 1'b0;
    if (accept) begin
      model_occ[slot] = 1'b0;
      model_pw[slot]  = '0;
      model_tries     = 0;
    end else if (!locked) begin
      model_tries++;
      if (model_tries == TRIES) model_locked = 1'b1;
    end
    checks++;
    if (exit_gate !== accept) begin
      errors++; $display("FAIL exit_gate slot %0d: got %0b expected %0b", slot, exit_gate, accept);
    end
    checks++;
    if (pswd_inc_exit !== (!locked && !accept)) begin
      errors++; $display("FAIL pswd_inc_exit slot %0d: got %0b expected %0b", slot, pswd_inc_exit, !locked && !accept);
    end
    checks++;
    if (lockout !== model_locked) begin
      errors++; $display("FAIL exit_lockout: got %0b expected %0b", lockout, model_locked);
    end
    checks++;
    if (occupied !== model_vec() || free_count !== 3'(model_free()) || full !== (model_free() == 0)) begin
      errors++; $display("FAIL exit_lot: got %b/%0d/%0b expected %b/%0d", occupied, free_count, full, model_vec(), model_free());
    end
  endtask

  // seen = lockout-high cycles already observed by the caller.
  task automatic wait_lockout(input int seen);
    int cnt, guard;
    cnt = seen;
    guard = 0;
    while (lockout === 1'b1 && guard < 4 * LOCKC) begin
      tick();
      guard++;
      if (lockout === 1'b1) cnt++;
    end
    checks++;
    if (cnt != LOCKC) begin
      errors++; $display("FAIL lockout_duration: got %0d cycles expected %0d", cnt, LOCKC);
    end
    model_locked = 1'b0;
    model_tries  = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_model();
    tick(); tick();
    checks++;
    if (occupied !== 4'b0000 || free_count !== 3'd4 || full !== 1'b0) begin
      errors++; $display("FAIL reset_lot: got %b/%0d/%0b expected 0000/4/0", occupied, free_count, full);
    end
    checks++;
    if ({assign_valid, entry_gate, exit_gate, pswd_inc_entry, pswd_inc_exit, entry_timeout, lockout} !== 7'd0
        || assigned_slot !== 2'd0) begin
      errors++; $display("FAIL reset_pulses: got %b slot %0d expected all zero",
        {assign_valid, entry_gate, exit_gate, pswd_inc_entry, pswd_inc_exit, entry_timeout, lockout}, assigned_slot);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_entry();
    do_entry(128'hA9D, 128'hA9D);
    checks++;
    if (occupied !== 4'b0001 || free_count !== 3'd3 || assigned_slot !== 2'd0) begin
      errors++; $display("FAIL basic_entry: got %b/%0d/slot %0d expected 0001/3/slot 0", occupied, free_count, assigned_slot);
    end
  endtask

  task automatic test_entry_mismatch();
    do_entry(128'h256, 128'h265);
    checks++;
    if (assigned_slot !== 2'd1 || occupied !== 4'b0011) begin
      errors++; $display("FAIL mismatch_retry: got slot %0d occ %b expected slot 1 occ 0011", assigned_slot, occupied);
    end
  endtask

  task automatic test_fill_and_exit();
    do_entry(rand_pw(), rand_pw());
    do_entry(128'h77, 128'h77);
    checks++;
    if (full !== 1'b1) begin
      errors++; $display("FAIL lot_full: got %0b expected 1", full);
    end
    do_entry(128'h55, 128'h55);
    do_exit(2, model_pw[2]);
    checks++;
    if (occupied !== 4'b1011 || full !== 1'b0) begin
      errors++; $display("FAIL exit_slot2: got %b/%0b expected 1011/0", occupied, full);
    end
    do_entry(128'h99, 128'h99);
    checks++;
    if (assigned_slot !== 2'd2) begin
      errors++; $display("FAIL refill_slot: got %0d expected 2", assigned_slot);
    end
  endtask

  // ALLOC and an exit of slot 0 land on the same edge; allocation must use pre-release occupancy.
  task automatic test_race();
    logic [127:0] p;
    do_exit(3, model_pw[3]);
    p = rand_pw();
    ir = 1'b1; tick(); ir = 1'b0;
    pass_entry1 = p; enter1 = 1'b1; tick(); enter1 = 1'b0;
    pass_entry2 = p; enter2 = 1'b1; tick(); enter2 = 1'b0;
    exit_num = 2'd0; pass_exit = model_pw[0]; enter3 = 1'b1; tick(); enter3 = 1'b0;
    model_occ[0] = 1'b0; model_pw[0] = '0; model_tries = 0;
    model_occ[3] = 1'b1; model_pw[3] = p;
    checks++;
    if (assign_valid !== 1'b1 || exit_gate !== 1'b1 || assigned_slot !== 2'd3) begin
      errors++; $display("FAIL race_pulses: got av %0b eg %0b slot %0d expected 1 1 3", assign_valid, exit_gate, assigned_slot);
    end
    checks++;
    if (occupied !== 4'b1110 || free_count !== 3'd1) begin
      errors++; $display("FAIL race_lot: got %b/%0d expected 1110/1", occupied, free_count);
    end
    tick();
  endtask

  task automatic test_lockout();
    logic [127:0] good;
    do_entry(128'hA9D, 128'hA9D);
    good = model_pw[0];
    for (int i = 0; i < TRIES; i++) do_exit(0, 128'h142);
    checks++;
    if (lockout !== 1'b1) begin
      errors++; $display("FAIL lockout_set: got %0b expected 1", lockout);
    end
    do_exit(0, good);
    wait_lockout(2);
    do_exit(0, good);
    checks++;
    if (occupied[0] !== 1'b0) begin
      errors++; $display("FAIL lockout_release: got %0b expected 0", occupied[0]);
    end
  endtask

  task automatic test_timeout();
    int k;
    logic [NS-1:0] occ0;
    occ0 = model_vec();
    ir = 1'b1; tick(); ir = 1'b0;
    k = 0;
    while (k < 2 * TMO) begin
      tick();
      k++;
      if (entry_timeout === 1'b1) break;
    end
    checks++;
    if (k != TMO) begin
      errors++; $display("FAIL timeout_latency: got %0d cycles expected %0d", k, TMO);
    end
    tick();
    checks++;
    if (entry_timeout !== 1'b0 || occupied !== occ0) begin
      errors++; $display("FAIL timeout_after: got %0b/%b expected 0/%b", entry_timeout, occupied, occ0);
    end
    // Back in IDLE: strobes without an ir edge must not allocate.
    pass_entry1 = 128'h3; enter1 = 1'b1; tick(); enter1 = 1'b0;
    pass_entry2 = 128'h3; enter2 = 1'b1; tick(); enter2 = 1'b0;
    tick();
    checks++;
    if (assign_valid !== 1'b0 || occupied !== occ0) begin
      errors++; $display("FAIL timeout_idle: got %0b/%b expected 0/%b", assign_valid, occupied, occ0);
    end
  endtask

  task automatic test_random();
    logic [127:0] p, q;
    int s;
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          p = rand_pw();
          do_entry(p, p);
        end
        1: begin
          p = rand_pw();
          q = p;
          q[$urandom_range(0, 127)] ^= 1'b1;
          do_entry(p, q);
        end
        2: begin
          s = $urandom_range(0, NS - 1);
          do_exit(s, model_pw[s]);
        end
        default: begin
          s = $urandom_range(0, NS - 1);
          do_exit(s, rand_pw());
        end
      endcase
      if (model_locked) wait_lockout(1);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; tick(); rst = 1'b0;
    clear_model();
    tick();
    do_entry(128'h11, 128'h11);
    do_entry(128'h22, 128'h22);
    ir = 1'b1; tick(); ir = 1'b0;
    pass_entry1 = 128'h33; enter1 = 1'b1; tick(); enter1 = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (occupied !== 4'b0000 || free_count !== 3'd4 || full !== 1'b0 || assigned_slot !== 2'd0 || lockout !== 1'b0) begin
      errors++; $display("FAIL reset_async: got %b/%0d/%0b slot %0d expected 0000/4/0 slot 0", occupied, free_count, full, assigned_slot);
    end
    tick();
    rst = 1'b0;
    clear_model();
    tick();
    do_entry(128'h44, 128'h44);
    checks++;
    if (assigned_slot !== 2'd0) begin
      errors++; $display("FAIL post_reset_slot: got %0d expected 0", assigned_slot);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_entry();
    test_entry_mismatch();
    test_fill_and_exit();
    test_race();
    test_lockout();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_ctrl_multi.md
Name: parking_ctrl_multi

Overview:
Clocked, parametrised successor of the 16-slot parking controller. It handles the entry sequence: IR car detect, password entry, password confirm, then automatic slot allocation. It also handles password-checked exit per slot, with a retry lockout and an entry timeout. It sits between the gate sensors/keypad front end and the gate actuator / display logic.

Parameters:
NUM_SLOTS, 16, number of parking slots (2..64)
PW_WIDTH, 128, password width in bits
SLOT_W, $clog2(NUM_SLOTS), slot index width (derived, localparam)
ENTRY_TIMEOUT, 1000, cycles allowed in any entry wait state before abort
MAX_TRIES, 3, consecutive bad exit passwords before lockout
LOCK_CYCLES, 500, exit lockout duration in cycles

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
ir  in  1  car-present sensor, level; rising edge starts entry
pass_entry1  in  PW_WIDTH  first password entry
enter1  in  1  strobe: capture pass_entry1
pass_entry2  in  PW_WIDTH  confirm password
enter2  in  1  strobe: compare pass_entry2
exit_num  in  SLOT_W  slot requesting exit
pass_exit  in  PW_WIDTH  exit password
enter3  in  1  strobe: exit request
occupied  out  NUM_SLOTS  per-slot occupancy
free_count  out  SLOT_W+1  number of free slots
full  out  1  level, free_count==0
assign_valid  out  1  1-cycle pulse, slot allocated
assigned_slot  out  SLOT_W  slot index, valid with assign_valid, held until the next allocation
entry_gate  out  1  1-cycle pulse with assign_valid
exit_gate  out  1  1-cycle pulse, exit accepted
pswd_inc_entry  out  1  1-cycle pulse, confirm mismatch
pswd_inc_exit  out  1  1-cycle pulse, exit rejected
entry_timeout  out  1  1-cycle pulse, entry aborted
lockout  out  1  level, exit path locked

Behaviour:
- Reset (async): all outputs 0 except free_count=NUM_SLOTS. Password store cleared to 0. Entry FSM goes to IDLE. Try counter and lock timer go to 0.
- All strobes are sampled on the rising clk edge. ir rising edge is detected against a registered ir.
- Entry FSM states: IDLE, WAIT_PW1, WAIT_PW2, ALLOC.
  - IDLE: ir rise and !full -> WAIT_PW1. ir rise while full -> stay IDLE; no pulse, full already high.
  - WAIT_PW1: enter1 -> latch pass_entry1, go to WAIT_PW2.
  - WAIT_PW2: enter2 with pass_entry2==latched pw -> ALLOC. Mismatch -> pswd_inc_entry pulse next cycle, go to WAIT_PW1.
  - ALLOC (one cycle): choose the lowest-index free slot from registered occupied. Store the password. Set the occupied bit. Pulse assign_valid and entry_gate. Go to IDLE.
  - Latency: enter2 edge to assign_valid = 2 cycles.
  - Timeout: a counter resets on each state entry. When it reaches ENTRY_TIMEOUT in WAIT_PW1 or WAIT_PW2, pulse entry_timeout, go to IDLE, and discard the latched pw.
  - enter1 in WAIT_PW2 and enter2 in WAIT_PW1 are ignored. ir edges outside IDLE are ignored.
  - If the last free slot is taken by an exit/entry race, ALLOC re-checks free slots. If none remain, go to IDLE with no pulse.
- Exit path (independent of entry FSM):
  - enter3 while !lockout: exit_num < NUM_SLOTS, slot occupied, and pass_exit==stored pw -> next cycle clear the occupied bit, clear the stored pw, pulse exit_gate, zero the try counter.
  - Otherwise: pulse pswd_inc_exit and increment the try counter.
  - When the try counter reaches MAX_TRIES: lockout=1 for LOCK_CYCLES cycles, then lockout=0 and try counter=0.
  - enter3 during lockout is ignored; no pulses.
- Simultaneous events: exit release and ALLOC in the same cycle both apply. ALLOC uses pre-release occupancy, so it never picks the slot being released that cycle. free_count reflects the net change (+1-1) on the following cycle.
- free_count and full are registered and consistent with occupied on the same cycle.
- Reset mid-operation aborts any entry in progress and empties the lot.

Test Plan:
- NUM_SLOTS=4. Reset, ir pulse, pass_entry1=pass_entry2=128'hA9D with strobes -> assign_valid pulse 2 cycles after enter2, assigned_slot=0, occupied=4'b0001, free_count=3.
- Entry with pass1=128'h256, pass2=128'h265 -> pswd_inc_entry pulse, FSM back in WAIT_PW1. Retry with 128'h256 twice -> slot 1 assigned.
- Fill all 4 slots -> full=1. A further ir rise produces no state change. Exit slot 2 with the correct pw -> exit_gate, occupied=4'b1011, full=0. Next entry gets slot 2.
- Three exits on slot 0 with wrong pw 128'h142 -> three pswd_inc_exit pulses, lockout=1. A correct enter3 during lockout is ignored. After LOCK_CYCLES, the correct pw releases slot 0.
- ir rise, then no enter1 for ENTRY_TIMEOUT cycles -> entry_timeout pulse, FSM IDLE, occupancy unchanged.
- Assert rst while in WAIT_PW2 with 2 slots occupied -> outputs zero immediately, free_count=4. Post-reset entry gets slot 0.
